bullet_pool_ctrl: RTL and testbench

Bullet scheduler for the doodler's weapon. Owns NUM_SLOTS bullet slots and decodes arrow-key fire requests with a per-frame cooldown. Allocates free slots, steps each live bullet once per frame, and retires bullets on playfield exit or on a hit report. Gives the colour mapper a per-pixel is_bullet query and gives collision logic the packed bullet positions.

---
 rtl/bullet_pool_ctrl_if.sv | 23 ++
 rtl/bullet_pool_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_bullet_pool_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_pool_ctrl_if.sv
// Collision-side bus of the bullet pool: hit reports flow into the pool,
// per-slot liveness and packed positions flow back out.
interface bullet_pool_ctrl_if #(
  parameter int NUM_SLOTS = 4
);
  logic                     hit_valid;
  logic [2:0]               hit_slot;
  logic [NUM_SLOTS-1:0]     bullet_active;
  logic [10*NUM_SLOTS-1:0]  BulletX_all;
  logic [10*NUM_SLOTS-1:0]  BulletY_all;

  // Collision logic reports hits and observes bullets.
  modport master (
    output hit_valid, hit_slot,
    input  bullet_active, BulletX_all, BulletY_all
  );

  // The pool consumes hits and publishes bullets.
  modport slave (
    input  hit_valid, hit_slot,
    output bullet_active, BulletX_all, BulletY_all
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// Bullet scheduler: decodes fire keys with a per-frame cooldown, allocates
// slots, steps live bullets once per frame and answers per-pixel queries.
module bullet_pool_ctrl #(
  parameter int         NUM_SLOTS = 4,
  parameter logic [9:0] X_MIN     = 10'd170,
  parameter logic [9:0] X_MAX     = 10'd469,
  parameter logic [9:0] SPEED_X   = 10'd4,
  parameter logic [9:0] SPEED_Y   = 10'd10,
  parameter logic [9:0] BULLET_S  = 10'd2,
  parameter logic [3:0] COOLDOWN  = 4'd6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        game_en,
  input  logic [7:0]  keycode,
  input  logic [7:0]  keycode_ext,
  input  logic [9:0]  DoodleX,
  input  logic [9:0]  DoodleY,
  input  logic [9:0]  DoodleS,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_bullet,
  output logic        shot_pulse,
  output logic [15:0] shots_fired,
  bullet_pool_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_FLY = 1'b1} slot_state_t;

  slot_state_t r_state     [NUM_SLOTS];
  slot_state_t w_state_nxt [NUM_SLOTS];
  logic [9:0]  r_x [NUM_SLOTS], r_y [NUM_SLOTS], r_vx [NUM_SLOTS], r_vy [NUM_SLOTS];
  logic [9:0]  w_x_nxt [NUM_SLOTS], w_y_nxt [NUM_SLOTS];
  logic [9:0]  w_vx_nxt [NUM_SLOTS], w_vy_nxt [NUM_SLOTS];
  logic [9:0]  w_nx [NUM_SLOTS], w_ny [NUM_SLOTS];
  logic        w_retire [NUM_SLOTS];

  logic [3:0]  r_cd, w_cd_nxt;
  logic        r_shot, w_shot_nxt;
  logic [15:0] r_shots, w_shots_nxt;
  logic        r_frame_q, r_frame_qq;
  logic        w_tick;
  logic        w_key_up, w_key_right, w_key_left, w_fire_req;
  logic [9:0]  w_fire_vx;
  logic        w_alloc;
  logic [2:0]  w_alloc_idx;
  logic        w_pix_hit;

  // Frame strobe history: one sampling flop, one edge-detect flop.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state is only ever assigned with <=, so every flop sees pre-edge values.
    if (!Reset) begin
      r_frame_q  <= 1'b0;
      r_frame_qq <= 1'b0;
    end else begin
      r_frame_q  <= frame_clk;
      r_frame_qq <= r_frame_q;
    end
  end

  assign w_tick = r_frame_q & ~r_frame_qq;

  // Fire-key decode; up beats right beats left on either keycode input.
  assign w_key_up    = (keycode == 8'd82) || (keycode_ext == 8'd82);
  assign w_key_right = (keycode == 8'd79) || (keycode_ext == 8'd79);
  assign w_key_left  = (keycode == 8'd80) || (keycode_ext == 8'd80);
  assign w_fire_req  = w_key_up | w_key_right | w_key_left;
  assign w_fire_vx   = w_key_up ? 10'd0 : (w_key_right ? SPEED_X : (10'd0 - SPEED_X));

  // Lowest-index idle slot from the registered mask; later iterations win,
  // so scanning downward leaves the lowest index selected.
  always_comb begin
    w_alloc     = 1'b0;
    w_alloc_idx = '0;
    if (game_en && w_tick && w_fire_req && (r_cd == '0)) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (r_state[i] == S_IDLE) begin
          w_alloc     = 1'b1;
          w_alloc_idx = 3'(i);
        end
      end
    end
  end

  // Candidate next position and exit test for every slot.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_nx[i]     = r_x[i] + r_vx[i];
      w_ny[i]     = r_y[i] + r_vy[i];
      w_retire[i] = (r_y[i] < SPEED_Y) || (w_nx[i] < X_MIN) || (w_nx[i] > X_MAX);
    end
  end

  // Slot FSM next-state, movement, allocation and cooldown.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_x_nxt[i]     = r_x[i];
      w_y_nxt[i]     = r_y[i];
      w_vx_nxt[i]    = r_vx[i];
      w_vy_nxt[i]    = r_vy[i];
    end
    w_cd_nxt    = r_cd;
    w_shot_nxt  = 1'b0;
    w_shots_nxt = r_shots;

    if (!game_en) begin
      for (int i = 0; i < NUM_SLOTS; i++) w_state_nxt[i] = S_IDLE;
      w_cd_nxt = '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (r_state[i] == S_FLY) begin
          if (bus.hit_valid && (bus.hit_slot == 3'(i))) begin
            w_state_nxt[i] = S_IDLE;
          end else if (w_tick) begin
            if (w_retire[i]) begin
              w_state_nxt[i] = S_IDLE;
            end else begin
              w_x_nxt[i] = w_nx[i];
              w_y_nxt[i] = w_ny[i];
            end
          end
        end
      end
      if (w_alloc) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (3'(i) == w_alloc_idx) begin
            w_state_nxt[i] = S_FLY;
            w_x_nxt[i]     = DoodleX;
            w_y_nxt[i]     = DoodleY - DoodleS;
            w_vx_nxt[i]    = w_fire_vx;
            w_vy_nxt[i]    = 10'd0 - SPEED_Y;
          end
        end
        w_cd_nxt    = COOLDOWN;
        w_shot_nxt  = 1'b1;
        w_shots_nxt = r_shots + 16'd1;
      end else if (w_tick && (r_cd != '0)) begin
        w_cd_nxt = r_cd - 4'd1;
      end
    end
  end

  // Slot, cooldown and counter registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: the slot arrays are small register files, not RAM, so they are reset like ordinary flops.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
        r_vx[i]    <= '0;
        r_vy[i]    <= '0;
      end
      r_cd    <= '0;
      r_shot  <= 1'b0;
      r_shots <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_x[i]     <= w_x_nxt[i];
        r_y[i]     <= w_y_nxt[i];
        r_vx[i]    <= w_vx_nxt[i];
        r_vy[i]    <= w_vy_nxt[i];
      end
      r_cd    <= w_cd_nxt;
      r_shot  <= w_shot_nxt;
      r_shots <= w_shots_nxt;
    end
  end

  // Pixel query: 11-bit sums so the window never wraps at the screen edges.
  always_comb begin
    w_pix_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((r_state[i] == S_FLY) &&
          ({1'b0, DrawX} + {1'b0, BULLET_S} >= {1'b0, r_x[i]}) &&
          ({1'b0, DrawX} <= {1'b0, r_x[i]} + {1'b0, BULLET_S}) &&
          ({1'b0, DrawY} + {1'b0, BULLET_S} >= {1'b0, r_y[i]}) &&
          ({1'b0, DrawY} <= {1'b0, r_y[i]} + {1'b0, BULLET_S}))
        w_pix_hit = 1'b1;
    end
  end

  // Publish registered state.
  always_comb begin
    bus.bullet_active = '0;
    bus.BulletX_all   = '0;
    bus.BulletY_all   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      bus.bullet_active[i]      = (r_state[i] == S_FLY);
      bus.BulletX_all[10*i +: 10] = r_x[i];
      bus.BulletY_all[10*i +: 10] = r_y[i];
    end
  end

  assign is_bullet   = w_pix_hit;
  assign shot_pulse  = r_shot;
  assign shots_fired = r_shots;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Self-checking bench for bullet_pool_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural model of the pool.
module tb_bullet_pool_ctrl;
  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        rst_n, frame_clk, game_en;
  logic [7:0]  keycode, keycode_ext;
  logic [9:0]  DoodleX, DoodleY, DoodleS, DrawX, DrawY;
  logic        is_bullet, shot_pulse;
  logic [15:0] shots_fired;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_seen = 0;

  bullet_pool_ctrl_if #(.NUM_SLOTS(N)) bus();

  bullet_pool_ctrl #(.NUM_SLOTS(N)) dut (
    .Clk(Clk), .Reset(rst_n), .frame_clk(frame_clk), .game_en(game_en),
    .keycode(keycode), .keycode_ext(keycode_ext),
    .DoodleX(DoodleX), .DoodleY(DoodleY), .DoodleS(DoodleS),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_bullet(is_bullet), .shot_pulse(shot_pulse), .shots_fired(shots_fired),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: plain integers, one entry per slot.
  bit m_act [N];
  int m_x [N], m_y [N], m_vx [N], m_vy [N];
  int m_cd, m_shots;
  bit m_pulse, m_f1, m_f2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one Clk edge using the inputs present at that edge.
  function automatic void model_update();
    bit tick, fire;
    int dvx, slot, nx;
    tick = m_f1 && !m_f2;
    m_f2 = m_f1;
    m_f1 = frame_clk;
    m_pulse = 0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
      end
      m_cd = 0; m_shots = 0; m_f1 = 0; m_f2 = 0;
      return;
    end
    if (!game_en) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
      m_cd = 0;
      return;
    end
    fire = 1; dvx = 0;
    if (keycode == 82 || keycode_ext == 82)      dvx = 0;
    else if (keycode == 79 || keycode_ext == 79) dvx = 4;
    else if (keycode == 80 || keycode_ext == 80) dvx = -4;
    else fire = 0;
    slot = -1;
    if (tick && fire && m_cd == 0)
      for (int i = 0; i < N; i++) if (!m_act[i]) begin slot = i; break; end
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (bus.hit_valid && int'(bus.hit_slot) == i) m_act[i] = 0;
        else if (tick) begin
          nx = ((m_x[i] + m_vx[i]) % 1024 + 1024) % 1024;
          if (m_y[i] < 10 || nx < 170 || nx > 469) m_act[i] = 0;
          else begin
            m_x[i] = nx;
            m_y[i] = ((m_y[i] + m_vy[i]) % 1024 + 1024) % 1024;
          end
        end
      end
    end
    if (slot >= 0) begin
      m_act[slot] = 1;
      m_x[slot]   = int'(DoodleX);
      m_y[slot]   = (int'(DoodleY) - int'(DoodleS) + 1024) % 1024;
      m_vx[slot]  = dvx;
      m_vy[slot]  = -10;
      m_cd = 6; m_pulse = 1; m_shots = (m_shots + 1) % 65536;
    end else if (tick && m_cd > 0) begin
      m_cd--;
    end
  endfunction

  task automatic check_all();
    logic [N-1:0]    ea;
    logic [10*N-1:0] ex, ey;
    bit eb;
    int dx, dy;
    ea = '0; ex = '0; ey = '0; eb = 0;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_act[i];
      ex[10*i +: 10] = 10'(m_x[i]);
      ey[10*i +: 10] = 10'(m_y[i]);
      dx = int'(DrawX) - m_x[i]; if (dx < 0) dx = -dx;
      dy = int'(DrawY) - m_y[i]; if (dy < 0) dy = -dy;
      if (m_act[i] && dx <= 2 && dy <= 2) eb = 1;
    end
    check("bullet_active", bus.bullet_active, ea);
    check("bullet_x", bus.BulletX_all, ex);
    check("bullet_y", bus.BulletY_all, ey);
    check("shot_pulse", shot_pulse, m_pulse);
    check("shots_fired", shots_fired, 64'(m_shots));
    check("is_bullet", is_bullet, eb);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    model_update();
    if (shot_pulse) pulse_seen++;
    check_all();
  endtask

  // One frame: strobe high for three Clks, optional hit in the tick cycle.
  task automatic frame(input bit hit_en = 0, input logic [2:0] hs = 3'd0);
    frame_clk = 1'b1; step();
    if (hit_en) begin bus.hit_valid = 1'b1; bus.hit_slot = hs; end
    step();
    bus.hit_valid = 1'b0; step();
    frame_clk = 1'b0; step(); step(); step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 4))
      0: return 8'd82;
      1: return 8'd79;
      2: return 8'd80;
      3: return 8'd0;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [10*N-1:0] v;
    int p0, fcnt, sel;
    rst_n = 1'b0; frame_clk = 1'b0; game_en = 1'b1;
    keycode = 8'd82; keycode_ext = 8'd0;
    DoodleX = 10'd300; DoodleY = 10'd400; DoodleS = 10'd16;
    DrawX = 10'd300; DrawY = 10'd384;
    bus.hit_valid = 1'b0; bus.hit_slot = 3'd0;

    // Reset with the fire key held.
    frame_clk = 1'b1; step(); frame_clk = 1'b0; step();
    check("rst_active", bus.bullet_active, 0);
    check("rst_shots", shots_fired, 0);
    check("rst_is_bullet", is_bullet, 0);
    rst_n = 1'b1;

    // First up shot, then one step.
    p0 = pulse_seen;
    frame();
    v = bus.BulletX_all; check("up_spawn_x", v[9:0], 300);
    v = bus.BulletY_all; check("up_spawn_y", v[9:0], 384);
    check("up_spawn_pulses", pulse_seen - p0, 1);
    keycode = 8'd0;
    frame();
    v = bus.BulletY_all; check("up_move_y", v[9:0], 374);

    // Held right key: spawns on frames 0, 7, 14.
    do_reset();
    keycode = 8'd79; DoodleY = 10'd470; DoodleS = 10'd0;
    repeat (20) frame();
    check("cooldown_active", bus.bullet_active, 4'b0111);
    check("cooldown_shots", shots_fired, 3);

    // Right edge exit.
    do_reset();
    DoodleX = 10'd466;
    frame();
    check("edge_spawn", bus.bullet_active, 1);
    keycode = 8'd0;
    frame();
    check("edge_retire", bus.bullet_active, 0);
    v = bus.BulletX_all; check("edge_x_held", v[9:0], 466);

    // Top exit without wrapping.
    do_reset();
    keycode = 8'd82; DoodleX = 10'd300; DoodleY = 10'd21; DoodleS = 10'd16;
    frame();
    v = bus.BulletY_all; check("top_spawn_y", v[9:0], 5);
    keycode = 8'd0;
    frame();
    check("top_retire", bus.bullet_active, 0);

    // Full pool, dropped request, hit during tick, refill on next tick.
    do_reset();
    keycode = 8'd82; DoodleY = 10'd470; DoodleS = 10'd0;
    repeat (29) frame();
    check("full_active", bus.bullet_active, 4'hF);
    check("full_shots", shots_fired, 4);
    frame(1'b1, 3'd2);
    check("hit_active", bus.bullet_active, 4'b1011);
    check("hit_shots", shots_fired, 4);
    frame();
    check("refill_active", bus.bullet_active, 4'hF);
    check("refill_shots", shots_fired, 5);
    v = bus.BulletY_all; check("refill_y", v[29:20], 470);

    // Pixel window sweep around (200,100).
    do_reset();
    keycode = 8'd82; DoodleX = 10'd200; DoodleY = 10'd116; DoodleS = 10'd16;
    frame();
    keycode = 8'd0;
    for (int x = 195; x <= 205; x++) begin
      DrawX = 10'(x); DrawY = 10'd100; step();
      check("sweep_x", is_bullet, (x >= 198 && x <= 202));
    end
    for (int y = 95; y <= 105; y++) begin
      DrawX = 10'd200; DrawY = 10'(y); step();
      check("sweep_y", is_bullet, (y >= 98 && y <= 102));
    end

    // Bullet at X=1 still covers DrawX=0.
    do_reset();
    keycode = 8'd82; DoodleX = 10'd1; DoodleY = 10'd200; DoodleS = 10'd0;
    frame();
    keycode = 8'd0; DrawX = 10'd0; DrawY = 10'd200; step();
    check("low_edge_pix", is_bullet, 1);

    // Randomized run against the model.
    do_reset();
    fcnt = 3;
    for (int c = 0; c < 4000; c++) begin
      if (--fcnt <= 0) begin frame_clk = ~frame_clk; fcnt = $urandom_range(2, 5); end
      rst_n   = ($urandom_range(0, 599) != 0);
      game_en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 4) == 0) begin keycode = pick_key(); keycode_ext = pick_key(); end
      bus.hit_valid = ($urandom_range(0, 9) == 0);
      bus.hit_slot  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        DoodleX = 10'($urandom_range(150, 490));
        DoodleY = 10'($urandom_range(0, 479));
        DoodleS = 10'($urandom_range(0, 40));
      end
      sel = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 0) begin
        DrawX = 10'((m_x[sel] + $urandom_range(0, 6) - 3 + 1024) % 1024);
        DrawY = 10'((m_y[sel] + $urandom_range(0, 6) - 3 + 1024) % 1024);
      end else begin
        DrawX = 10'($urandom); DrawY = 10'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
